spike_rate_encoder: RTL and testbench



---
 rtl/spike_rate_encoder.sv | 154 +++++++++++++++
 tb/tb_spike_rate_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns a frame of M unsigned intensities into M deterministic
// spike trains over N_STEPS timesteps using per-channel phase accumulators.
module spike_rate_encoder #(
    parameter int M       = 8,
    parameter int W       = 8,
    parameter int N_STEPS = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M*W-1:0] intensities,
    input  logic           step_en,
    output logic [M-1:0]   spikes_out,
    output logic           spike_valid,
    output logic [7:0]     step_idx,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_STEP = 8'(N_STEPS - 1);

    state_t         state_r;
    state_t         state_next_s;
    logic [M*W-1:0] frame_r;
    logic [W-1:0]   acc_r [M];
    logic [W:0]     sum_s [M];
    logic [M-1:0]   carry_s;
    logic [7:0]     cnt_r;
    logic           accept_s;
    logic           advance_s;
    logic           last_step_s;

    logic [M-1:0]   spikes_r;
    logic           spike_valid_r;
    logic [7:0]     step_idx_r;
    logic           frame_done_r;
    logic [M-1:0]   spikes_next_s;
    logic           spike_valid_next_s;
    logic [7:0]     step_idx_next_s;
    logic           frame_done_next_s;

    assign in_ready    = (state_r == IDLE);
    assign busy        = (state_r == RUN);
    assign spikes_out  = spikes_r;
    assign spike_valid = spike_valid_r;
    assign step_idx    = step_idx_r;
    assign frame_done  = frame_done_r;

    // Handshake qualifiers and per-channel accumulate; the carry out is the spike.
    always_comb begin
        accept_s    = (state_r == IDLE) && in_valid;
        advance_s   = (state_r == RUN) && step_en;
        last_step_s = advance_s && (cnt_r == LAST_STEP);
        for (int i = 0; i < M; i++) begin
            sum_s[i]   = {1'b0, acc_r[i]} + {1'b0, frame_r[i*W +: W]};
            carry_s[i] = sum_s[i][W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: the final step hands straight back to IDLE so the
    // following frame can be taken in the same cycle as frame_done.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output next values; spikes are forced to zero on non-step cycles.
    always_comb begin
        spikes_next_s      = {M{1'b0}};
        spike_valid_next_s = 1'b0;
        frame_done_next_s  = 1'b0;
        step_idx_next_s    = step_idx_r;
        if (advance_s) begin
            spikes_next_s      = carry_s;
            spike_valid_next_s = 1'b1;
            frame_done_next_s  = last_step_s;
            step_idx_next_s    = cnt_r;
        end else begin
            spikes_next_s      = {M{1'b0}};
            spike_valid_next_s = 1'b0;
            frame_done_next_s  = 1'b0;
            step_idx_next_s    = step_idx_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            spikes_r      <= {M{1'b0}};
            spike_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            step_idx_r    <= 8'd0;
        end else begin
            spikes_r      <= spikes_next_s;
            spike_valid_r <= spike_valid_next_s;
            frame_done_r  <= frame_done_next_s;
            step_idx_r    <= step_idx_next_s;
        end
    end

    // Frame latch, phase accumulators and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_r <= {(M*W){1'b0}};
            cnt_r   <= 8'd0;
            for (int i = 0; i < M; i++) begin
                acc_r[i] <= {W{1'b0}};
            end
        end else if (accept_s) begin
            frame_r <= intensities;
            cnt_r   <= 8'd0;
            for (int i = 0; i < M; i++) begin
                acc_r[i] <= {W{1'b0}};
            end
        end else if (advance_s) begin
            cnt_r <= last_step_s ? 8'd0 : (cnt_r + 8'd1);
            for (int i = 0; i < M; i++) begin
                acc_r[i] <= sum_s[i][W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: directed frames plus random
// frames checked against an arithmetic floor(k*I/2^W) spike model.
module tb_spike_rate_encoder;

    localparam int M = 8;
    localparam int W = 8;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, step_en;
    logic [M*W-1:0] intensities;
    logic           in_ready, spike_valid, busy, frame_done;
    logic [M-1:0]   spikes_out;
    logic [7:0]     step_idx;

    logic           in_valid_1, step_en_1;
    logic [M*W-1:0] intensities_1;
    logic           in_ready_1, spike_valid_1, busy_1, frame_done_1;
    logic [M-1:0]   spikes_out_1;
    logic [7:0]     step_idx_1;

    int checks   = 0;
    int failures = 0;
    int tot [M];

    always #5 clk = ~clk;

    spike_rate_encoder #(.M(M), .W(W), .N_STEPS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .intensities(intensities), .step_en(step_en), .spikes_out(spikes_out),
        .spike_valid(spike_valid), .step_idx(step_idx), .busy(busy),
        .frame_done(frame_done)
    );

    spike_rate_encoder #(.M(M), .W(W), .N_STEPS(1)) dut_1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .intensities(intensities_1), .step_en(step_en_1), .spikes_out(spikes_out_1),
        .spike_valid(spike_valid_1), .step_idx(step_idx_1), .busy(busy_1),
        .frame_done(frame_done_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel i spikes on step k iff floor(k*I/2^W) steps up.
    function automatic logic [M-1:0] exp_spikes(input logic [M*W-1:0] f, input int k);
        logic [M-1:0] s;
        for (int i = 0; i < M; i++) begin
            int iv;
            iv   = int'(f[i*W +: W]);
            s[i] = ((k * iv) / (2 ** W)) != (((k - 1) * iv) / (2 ** W));
        end
        return s;
    endfunction

    function automatic logic [M*W-1:0] rand_frame();
        return {$urandom, $urandom};
    endfunction

    task automatic accept_frame();
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", in_ready, 0);
        chk("accept_valid", spike_valid, 0);
    endtask

    task automatic load(input logic [M*W-1:0] f);
        in_valid    = 1'b1;
        intensities = f;
        accept_frame();
    endtask

    // Issue 'count' steps spaced by 'gap' cycles; nv/nf are driven on
    // in_valid/intensities throughout (ignored in RUN, taken after last step).
    task automatic step_frame(input logic [M*W-1:0] f, input int gap, input int count,
                              input logic nv, input logic [M*W-1:0] nf);
        for (int i = 0; i < M; i++) tot[i] = 0;
        for (int k = 1; k <= count; k++) begin
            in_valid    = nv;
            intensities = nf;
            step_en     = 1'b1;
            @(negedge clk);
            step_en = 1'b0;
            chk("step_valid", spike_valid, 1);
            chk("step_spikes", spikes_out, exp_spikes(f, k));
            chk("step_idx", step_idx, k - 1);
            chk("step_done", frame_done, k == N);
            chk("step_ready", in_ready, k == N);
            chk("step_busy", busy, k != N);
            for (int i = 0; i < M; i++) tot[i] += int'(spikes_out[i]);
            if (k < count) begin
                for (int g = 1; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_valid", spike_valid, 0);
                    chk("gap_spikes", spikes_out, 0);
                    chk("gap_done", frame_done, 0);
                end
            end
        end
        if (count == N) begin
            for (int i = 0; i < M; i++) begin
                chk("frame_total", tot[i], (N * int'(f[i*W +: W])) / (2 ** W));
            end
        end
    endtask

    initial begin
        int a_int [M] = '{0, 16, 64, 128, 192, 255, 1, 32};
        int a_tot [M] = '{0, 1, 4, 8, 12, 15, 0, 2};
        logic [M*W-1:0] fa, fc, fr;

        for (int i = 0; i < M; i++) fa[i*W +: W] = 8'(a_int[i]);
        reset = 1'b1; in_valid = 1'b0; step_en = 1'b0; intensities = '0;
        in_valid_1 = 1'b0; step_en_1 = 1'b0; intensities_1 = '0;
        @(negedge clk);
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        reset   = 1'b0;
        chk("rst_valid", spike_valid, 0);
        chk("rst_idx", step_idx, 0);

        // step_en in IDLE must do nothing
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        chk("idle_valid", spike_valid, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_spikes", spikes_out, 0);
        chk("idle_idx", step_idx, 0);
        chk("idle_done", frame_done, 0);

        // Directed frame, in_valid held with another frame through RUN,
        // which is then taken back-to-back on the frame_done cycle.
        fc = rand_frame();
        load(fa);
        step_frame(fa, 1, N, 1'b1, fc);
        for (int i = 0; i < M; i++) chk("rate_total_a", tot[i], a_tot[i]);
        accept_frame();
        step_frame(fc, 1, N, 1'b0, '0);

        // Same directed frame with step_en every third cycle.
        load(fa);
        step_frame(fa, 3, N, 1'b0, '0);
        for (int i = 0; i < M; i++) chk("gapped_total_a", tot[i], a_tot[i]);

        repeat (3) begin
            fr = rand_frame();
            load(fr);
            step_frame(fr, int'($urandom_range(1, 3)), N, 1'b0, '0);
        end

        // Reset after step 5, with in_valid and step_en also asserted.
        fr = rand_frame();
        load(fr);
        step_frame(fr, 1, 5, 1'b0, '0);
        reset = 1'b1; step_en = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; step_en = 1'b0; in_valid = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_done", frame_done, 0);
        chk("midrst_valid", spike_valid, 0);
        chk("midrst_spikes", spikes_out, 0);
        chk("midrst_idx", step_idx, 0);
        load({M{8'd128}});
        step_frame({M{8'd128}}, 1, N, 1'b0, '0);
        for (int i = 0; i < M; i++) chk("midrst_total_128", tot[i], 8);

        // Single-step build: I=200 and I=255 both yield no spike.
        for (int t = 0; t < 2; t++) begin
            in_valid_1    = 1'b1;
            intensities_1 = (t == 0) ? {M{8'd200}} : {M{8'd255}};
            @(negedge clk);
            in_valid_1 = 1'b0;
            chk("n1_busy", busy_1, 1);
            step_en_1 = 1'b1;
            @(negedge clk);
            step_en_1 = 1'b0;
            chk("n1_valid", spike_valid_1, 1);
            chk("n1_done", frame_done_1, 1);
            chk("n1_spikes", spikes_out_1, 0);
            chk("n1_ready", in_ready_1, 1);
            chk("n1_idx", step_idx_1, 0);
        end

        @(negedge clk);
        chk("end_done", frame_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
